dmem_bus_ctrl: RTL and testbench
================================

# dmem_bus_ctrl

Data-memory bus controller sitting directly downstream of the multicycle datapath's data bus. It accepts the datapath's address, write data, read/write enables and byte-enables, and runs a fixed-latency access against a synchronous single-port word RAM with a configurable number of wait states. It returns read data and a one-cycle ready pulse so the control FSM can hold its memory state until the access completes.

## Interface
Parameters:
- ADDR_BASE, 32'h1001_0000, byte address mapped to RAM word 0.
- DEPTH_WORDS, 4096, RAM depth in 32-bit words; power of two.
- WAIT_STATES, 1, extra cycles inserted before the RAM strobe; legal range 0..15.

Ports. One clock; reset is synchronous and active-high.
- iCLK  in  1  clock; all state changes on rising edge.
- iRST  in  1  synchronous active-high reset.
- iDwAddress  in  32  byte address.
- iDwWriteData  in  32  store data, already lane-aligned.
- iDwWriteEnable  in  1  write request (level).
- iDwReadEnable  in  1  read request (level).
- iDwByteEnable  in  4  byte lanes for writes.
- oDwReadData  out  32  registered read data.
- oDwReady  out  1  one-cycle completion pulse.
- oBusy  out  1  high whenever state is not IDLE.
- oFault  out  1  one-cycle misalignment pulse, coincident with oDwReady.
- oRamAddr  out  log2(DEPTH_WORDS)  RAM word address.
- oRamWData  out  32  RAM write data.
- oRamBE  out  4  RAM byte enables.
- oRamWE  out  1  RAM write strobe.
- oRamRE  out  1  RAM read strobe.
- iRamRData  in  32  RAM read data, valid the cycle after oRamRE.

## Operation
- FSM states: IDLE, WAIT, ACCESS, LATCH, DONE.
- IDLE: if iDwWriteEnable or iDwReadEnable, latch address, data, BE and op; go to WAIT if WAIT_STATES>0, else ACCESS.
- Both enables high: write wins; the read is dropped.
- WAIT: 4-bit counter loaded with WAIT_STATES-1; decrement each cycle; go to ACCESS at 0.
- ACCESS: oRamWE or oRamRE high for exactly this cycle, driven from state; go to LATCH.
- LATCH: for reads, capture iRamRData into oDwReadData; go to DONE.
- DONE: oDwReady=1; go to IDLE. A request still asserted in the following IDLE cycle is a new access.
- Range: ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS. oRamAddr = (addr-ADDR_BASE)[log2(DEPTH_WORDS)+1:2].
- Out of range: no RAM strobe; reads load 0 into oDwReadData; writes are dropped. Latency is unchanged.
- oDwReadData holds the last read value; writes do not change it.
- Inputs are ignored outside IDLE.

## Timing
- Request sampled in cycle 0. WAIT occupies cycles 1..W. ACCESS is cycle W+1, LATCH W+2, DONE W+3. Read and write latency are both W+3 cycles.
- Back-to-back accesses: the next sample is possible in cycle W+4.
- Reset values: oDwReadData=0, oDwReady=0, oBusy=0, oFault=0, all RAM strobes 0, oRamAddr/oRamWData/oRamBE=0, state IDLE.
- Reset in any state: IDLE at the next edge; no ready pulse. A strobe already on the bus during an ACCESS cycle with iRST high still completes at that edge.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A request is misaligned if BE=4'b1111 with addr[1:0]!=0, or a two-lane BE with addr[0]=1.
  - On a misaligned request: no RAM strobe, read data forced to 0, oFault pulses with oDwReady, latency unchanged.
- DMEM_ALIGN_CHECK_EN undefined: oFault tied 0; the access proceeds on the word address, ignoring addr[1:0].

## Structure
- Shared package/header dmem_pkg holds:
  - state encoding localparams (IDLE=0, WAIT=1, ACCESS=2, LATCH=3, DONE=4);
  - default ADDR_BASE;
  - the WAIT_STATES maximum (15).
- One sub-module, dmem_align_check: combinational addr[1:0]/BE check returning the misalignment flag. It is instantiated only under DMEM_ALIGN_CHECK_EN.

## Test plan
- WAIT_STATES=1, write 32'hDEADBEEF BE=4'hF at 32'h1001_0008 -> oRamWE in cycle 2 with oRamAddr=2; oDwReady in cycle 4.
- Read back 32'h1001_0008 -> oRamRE in cycle 2; oDwReadData=32'hDEADBEEF with oDwReady in cycle 4.
- WAIT_STATES=0, read and write asserted together -> write only, oRamRE never high, ready in cycle 3.
- Read 32'h0000_0100 (out of range) -> no RAM strobe, oDwReadData=0, ready at nominal latency.
- With DMEM_ALIGN_CHECK_EN, BE=4'hF at 32'h1001_0002 -> no strobe, oFault=1 with oDwReady; without the macro -> write to word 0, oFault=0.
- iRST asserted during WAIT -> IDLE next cycle, no strobe, no ready, all outputs 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory bus controller: FSM state encoding,
// default address map, wait-state limit and a byte-lane helper.
package dmem_pkg;

   localparam logic [2:0]  ST_IDLE   = 3'd0;
   localparam logic [2:0]  ST_WAIT   = 3'd1;
   localparam logic [2:0]  ST_ACCESS = 3'd2;
   localparam logic [2:0]  ST_LATCH  = 3'd3;
   localparam logic [2:0]  ST_DONE   = 3'd4;

   localparam logic [31:0] DMEM_ADDR_BASE_DEF = 32'h1001_0000;
   localparam int          DMEM_WAIT_MAX      = 32'sd15;

   function automatic logic dmem_two_lanes(input logic [3:0] be);
      return ($countones(be) == 32'sd2);
   endfunction

endpackage

// File: rtl/dmem_align_check.sv
// Combinational misalignment detector: a full-word access must be word aligned,
// a two-lane access must be halfword aligned.
module dmem_align_check
   import dmem_pkg::*;
(
   input  logic [1:0] addr_lo,
   input  logic [3:0] be,
   output logic       misaligned
);

   // Flag word accesses off a word boundary and halfword accesses on an odd byte.
   always_comb begin
      misaligned = 1'b0;
      if (be == 4'b1111) begin
         misaligned = (addr_lo != 2'b00);
      end else if (dmem_two_lanes(be)) begin
         misaligned = addr_lo[0];
      end else begin
         misaligned = 1'b0;
      end
   end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Fixed-latency bridge from the datapath data bus to a synchronous single-port
// word RAM. Define DMEM_ALIGN_CHECK_EN to fault misaligned requests.
module dmem_bus_ctrl
   import dmem_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = DMEM_ADDR_BASE_DEF,
   parameter int          DEPTH_WORDS = 32'sd4096,
   parameter int          WAIT_STATES = 32'sd1
) (
   input  logic                           iCLK,
   input  logic                           iRST,
   input  logic [31:0]                    iDwAddress,
   input  logic [31:0]                    iDwWriteData,
   input  logic                           iDwWriteEnable,
   input  logic                           iDwReadEnable,
   input  logic [3:0]                     iDwByteEnable,
   output logic [31:0]                    oDwReadData,
   output logic                           oDwReady,
   output logic                           oBusy,
   output logic                           oFault,
   output logic [$clog2(DEPTH_WORDS)-1:0] oRamAddr,
   output logic [31:0]                    oRamWData,
   output logic [3:0]                     oRamBE,
   output logic                           oRamWE,
   output logic                           oRamRE,
   input  logic [31:0]                    iRamRData
);

   localparam int AW = $clog2(DEPTH_WORDS);
   // Oversized wait counts saturate instead of wrapping the 4-bit counter.
   localparam int         WS_EFF    = (WAIT_STATES > DMEM_WAIT_MAX) ? DMEM_WAIT_MAX : WAIT_STATES;
   localparam logic [3:0] WAIT_LOAD = (WS_EFF > 32'sd0) ? 4'(WS_EFF - 32'sd1) : 4'd0;
   localparam logic [2:0] ST_FIRST  = (WS_EFF > 32'sd0) ? ST_WAIT : ST_ACCESS;

   logic [2:0]    state_r;
   logic [3:0]    wait_cnt_r;
   logic          op_write_r;
   logic          ok_r;
   logic          misalign_r;
   logic [31:0]   rdata_r;
   logic [AW-1:0] ram_addr_r;
   logic [31:0]   ram_wdata_r;
   logic [3:0]    ram_be_r;
   logic          ram_we_r;
   logic          ram_re_r;
   logic          ready_r;
   logic          busy_r;
   logic          fault_r;

   logic [2:0]    state_nxt_s;
   logic [3:0]    cnt_nxt_s;
   logic          op_write_nxt_s;
   logic          ok_nxt_s;
   logic          misalign_nxt_s;
   logic          take_s;
   logic          in_range_s;
   logic          misalign_s;
   logic [31:0]   offset_s;
   logic          unused_s;

`ifdef DMEM_ALIGN_CHECK_EN
   dmem_align_check u_align_check (
      .addr_lo    (iDwAddress[1:0]),
      .be         (iDwByteEnable),
      .misaligned (misalign_s)
   );
`else
   assign misalign_s = 1'b0;
`endif

   assign offset_s = iDwAddress - ADDR_BASE;
   assign unused_s = ^offset_s[1:0];

   // Address decode and request acceptance; only IDLE looks at the bus.
   always_comb begin
      in_range_s = 1'b0;
      if (iDwAddress >= ADDR_BASE) begin
         in_range_s = (offset_s[31:AW+2] == '0);
      end else begin
         in_range_s = 1'b0;
      end
      take_s = (state_r == ST_IDLE) && (iDwWriteEnable || iDwReadEnable);
      if (take_s) begin
         op_write_nxt_s = iDwWriteEnable;
         ok_nxt_s       = in_range_s && !misalign_s;
         misalign_nxt_s = misalign_s;
      end else begin
         op_write_nxt_s = op_write_r;
         ok_nxt_s       = ok_r;
         misalign_nxt_s = misalign_r;
      end
   end

   // Next-state logic for the access sequencer and its wait counter.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = wait_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (take_s) begin
               state_nxt_s = ST_FIRST;
               cnt_nxt_s   = WAIT_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_r == 4'd0) begin
               state_nxt_s = ST_ACCESS;
            end else begin
               cnt_nxt_s = wait_cnt_r - 4'd1;
            end
         end
         ST_ACCESS: state_nxt_s = ST_LATCH;
         ST_LATCH:  state_nxt_s = ST_DONE;
         ST_DONE:   state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // State, request capture and outputs registered from the next state.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_r     <= ST_IDLE;
         wait_cnt_r  <= 4'd0;
         op_write_r  <= 1'b0;
         ok_r        <= 1'b0;
         misalign_r  <= 1'b0;
         rdata_r     <= 32'd0;
         ram_addr_r  <= '0;
         ram_wdata_r <= 32'd0;
         ram_be_r    <= 4'd0;
         ram_we_r    <= 1'b0;
         ram_re_r    <= 1'b0;
         ready_r     <= 1'b0;
         busy_r      <= 1'b0;
         fault_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= cnt_nxt_s;
         op_write_r <= op_write_nxt_s;
         ok_r       <= ok_nxt_s;
         misalign_r <= misalign_nxt_s;
         if (take_s) begin
            ram_addr_r  <= offset_s[AW+1:2];
            ram_wdata_r <= iDwWriteData;
            ram_be_r    <= iDwByteEnable;
         end
         // Refused reads return zero so stale RAM data never reaches the core.
         if ((state_r == ST_LATCH) && !op_write_r) begin
            rdata_r <= ok_r ? iRamRData : 32'd0;
         end
         ram_we_r <= (state_nxt_s == ST_ACCESS) && ok_nxt_s && op_write_nxt_s;
         ram_re_r <= (state_nxt_s == ST_ACCESS) && ok_nxt_s && !op_write_nxt_s;
         ready_r  <= (state_nxt_s == ST_DONE);
         busy_r   <= (state_nxt_s != ST_IDLE);
         fault_r  <= (state_nxt_s == ST_DONE) && misalign_nxt_s;
      end
   end

   assign oDwReadData = rdata_r;
   assign oDwReady    = ready_r;
   assign oBusy       = busy_r;
   assign oFault      = fault_r;
   assign oRamAddr    = ram_addr_r;
   assign oRamWData   = ram_wdata_r;
   assign oRamBE      = ram_be_r;
   assign oRamWE      = ram_we_r;
   assign oRamRE      = ram_re_r;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: instance A runs one wait state, instance B none.
module tb_dmem_bus_ctrl;

   localparam logic [31:0] BASE = 32'h1001_0000;

   logic iCLK = 1'b0;
   logic iRST;
   always #5 iCLK = ~iCLK;

   logic [31:0] addr_a, wdata_a, rdata_a, ram_wdata_a, ram_rdata_a;
   logic        we_a, re_a, ready_a, busy_a, fault_a, ram_we_a, ram_re_a;
   logic [3:0]  be_a, ram_be_a;
   logic [11:0] ram_addr_a;
   logic [31:0] addr_b, wdata_b, rdata_b, ram_wdata_b, ram_rdata_b;
   logic        we_b, re_b, ready_b, busy_b, fault_b, ram_we_b, ram_re_b;
   logic [3:0]  be_b, ram_be_b;
   logic [11:0] ram_addr_b;

   dmem_bus_ctrl #(.ADDR_BASE(BASE), .DEPTH_WORDS(4096), .WAIT_STATES(1)) u_dut_a (
      .iCLK(iCLK), .iRST(iRST), .iDwAddress(addr_a), .iDwWriteData(wdata_a),
      .iDwWriteEnable(we_a), .iDwReadEnable(re_a), .iDwByteEnable(be_a),
      .oDwReadData(rdata_a), .oDwReady(ready_a), .oBusy(busy_a), .oFault(fault_a),
      .oRamAddr(ram_addr_a), .oRamWData(ram_wdata_a), .oRamBE(ram_be_a),
      .oRamWE(ram_we_a), .oRamRE(ram_re_a), .iRamRData(ram_rdata_a));

   dmem_bus_ctrl #(.ADDR_BASE(BASE), .DEPTH_WORDS(4096), .WAIT_STATES(0)) u_dut_b (
      .iCLK(iCLK), .iRST(iRST), .iDwAddress(addr_b), .iDwWriteData(wdata_b),
      .iDwWriteEnable(we_b), .iDwReadEnable(re_b), .iDwByteEnable(be_b),
      .oDwReadData(rdata_b), .oDwReady(ready_b), .oBusy(busy_b), .oFault(fault_b),
      .oRamAddr(ram_addr_b), .oRamWData(ram_wdata_b), .oRamBE(ram_be_b),
      .oRamWE(ram_we_b), .oRamRE(ram_re_b), .iRamRData(ram_rdata_b));

   // Synchronous RAM models, one per instance
   logic [31:0] mem_a [4096];
   logic [31:0] mem_b [4096];
   always @(posedge iCLK) begin
      if (ram_we_a) for (int b = 0; b < 4; b++) if (ram_be_a[b]) mem_a[ram_addr_a][8*b +: 8] <= ram_wdata_a[8*b +: 8];
      if (ram_re_a) ram_rdata_a <= mem_a[ram_addr_a];
   end
   always @(posedge iCLK) begin
      if (ram_we_b) for (int b = 0; b < 4; b++) if (ram_be_b[b]) mem_b[ram_addr_b][8*b +: 8] <= ram_wdata_b[8*b +: 8];
      if (ram_re_b) ram_rdata_b <= mem_b[ram_addr_b];
   end

   // Monitor view of whichever instance is currently exercised
   bit cur = 1'b0;
   logic [31:0] m_rdata, m_wdata;
   logic        m_ready, m_busy, m_fault, m_we, m_re;
   logic [3:0]  m_be;
   logic [11:0] m_addr;
   assign m_rdata = cur ? rdata_b     : rdata_a;
   assign m_wdata = cur ? ram_wdata_b : ram_wdata_a;
   assign m_ready = cur ? ready_b     : ready_a;
   assign m_busy  = cur ? busy_b      : busy_a;
   assign m_fault = cur ? fault_b     : fault_a;
   assign m_we    = cur ? ram_we_b    : ram_we_a;
   assign m_re    = cur ? ram_re_b    : ram_re_a;
   assign m_be    = cur ? ram_be_b    : ram_be_a;
   assign m_addr  = cur ? ram_addr_b  : ram_addr_a;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      logic        we;
      logic        re;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          lat;
      int          start;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] ref_mem [int];
   logic [31:0] last_rd [2];
   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int strobe_tot = 0;
   int ready_tot = 0;
   bit seen_strobe = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge iCLK) cyc <= cyc + 1;

   // Strobe and completion monitor against the scoreboard head
   always @(negedge iCLK) begin
      exp_t e;
      if (m_we || m_re) begin
         strobe_tot++;
         if (sb_q.size() == 0) begin
            check_eq("strobe_unexpected", 32'(m_we | m_re), 32'd0);
         end else begin
            seen_strobe = 1'b1;
            check_eq("strobe_cycle", cyc - sb_q[0].start, sb_q[0].lat - 2);
            check_eq("strobe_we", 32'(m_we), 32'(sb_q[0].we));
            check_eq("strobe_re", 32'(m_re), 32'(sb_q[0].re));
            check_eq("strobe_addr", 32'(m_addr), 32'(sb_q[0].addr));
            check_eq("strobe_busy", 32'(m_busy), 32'd1);
            if (m_we) begin
               check_eq("strobe_wdata", m_wdata, sb_q[0].wdata);
               check_eq("strobe_be", 32'(m_be), 32'(sb_q[0].be));
            end
         end
      end
      if (m_ready) begin
         ready_tot++;
         if (sb_q.size() == 0) begin
            check_eq("ready_unexpected", 32'(m_ready), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_eq("ready_latency", cyc - e.start, e.lat);
            check_eq("read_data", m_rdata, e.rdata);
            check_eq("fault", 32'(m_fault), 32'(e.fault));
            check_eq("strobe_seen", 32'(seen_strobe), 32'(e.we | e.re));
            seen_strobe = 1'b0;
         end
      end
   end

   task automatic issue(input bit sel, input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      exp_t        e;
      logic        inr, mis, ok;
      logic [31:0] off, w;
      int          key;
      off = a - BASE;
      inr = (a >= BASE) && (off < 32'h4000);
      mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis = ((be == 4'hF) && (a[1:0] != 2'b00)) || (($countones(be) == 2) && a[0]);
`endif
      ok      = inr && !mis;
      e.addr  = off[13:2];
      e.wdata = d;
      e.be    = be;
      e.fault = mis;
      e.we    = we && ok;
      e.re    = !we && re && ok;
      e.lat   = sel ? 3 : 4;
      key     = int'(sel) * 4096 + int'(off[13:2]);
      if (we) begin
         if (ok) begin
            w = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
            ref_mem[key] = w;
         end
         e.rdata = last_rd[sel];
      end else begin
         e.rdata = (ok && ref_mem.exists(key)) ? ref_mem[key] : 32'h0;
         last_rd[sel] = e.rdata;
      end
      @(negedge iCLK);
      cur = sel;
      if (sel) begin
         addr_b = a; wdata_b = d; we_b = we; re_b = re; be_b = be;
      end else begin
         addr_a = a; wdata_a = d; we_a = we; re_a = re; be_a = be;
      end
      e.start = cyc;
      sb_q.push_back(e);
      @(posedge iCLK);
      #1;
      we_a = 1'b0; re_a = 1'b0; we_b = 1'b0; re_b = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (sb_q.size() == 0) break;
         @(negedge iCLK);
      end
      check_eq("done_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
      @(negedge iCLK);
      check_eq("idle_busy", 32'(m_busy), 32'd0);
   endtask

   task automatic check_zero(input bit sel, input string pfx);
      cur = sel;
      #1;
      check_eq({pfx, "_rdata"}, m_rdata, 32'd0);
      check_eq({pfx, "_ctrl"}, {23'd0, m_ready, m_busy, m_fault, m_we, m_re, m_be}, 32'd0);
      check_eq({pfx, "_ramaddr"}, 32'(m_addr), 32'd0);
      check_eq({pfx, "_ramwdata"}, m_wdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, r0;
      iRST = 1'b1;
      addr_a = 32'd0; wdata_a = 32'd0; we_a = 1'b0; re_a = 1'b0; be_a = 4'd0;
      addr_b = 32'd0; wdata_b = 32'd0; we_b = 1'b0; re_b = 1'b0; be_b = 4'd0;
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      check_zero(1'b0, "rst_a");
      check_zero(1'b1, "rst_b");
      iRST = 1'b0;

      issue(1'b0, 1'b1, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF);
      issue(1'b0, 1'b0, 1'b1, 32'h1001_0008, 32'h0, 4'hF);
      issue(1'b0, 1'b1, 1'b0, 32'h1001_0010, 32'h1111_2222, 4'hF);
      issue(1'b0, 1'b1, 1'b0, 32'h1001_0010, 32'h5555_AAAA, 4'h3);
      issue(1'b0, 1'b0, 1'b1, 32'h1001_0010, 32'h0, 4'hF);
      issue(1'b0, 1'b1, 1'b0, 32'h1001_3FFC, 32'h0BAD_F00D, 4'hF);
      issue(1'b0, 1'b0, 1'b1, 32'h1001_3FFC, 32'h0, 4'hF);
      issue(1'b0, 1'b1, 1'b0, 32'h1001_4000, 32'h1234_5678, 4'hF);
      issue(1'b0, 1'b0, 1'b1, 32'h1001_4000, 32'h0, 4'hF);
      issue(1'b0, 1'b0, 1'b1, 32'h1001_0008, 32'h0, 4'hF);
      issue(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'hF);
      // Zero wait states, both enables: write only
      issue(1'b1, 1'b1, 1'b1, 32'h1001_0020, 32'hA5A5_5A5A, 4'hF);
      issue(1'b1, 1'b0, 1'b1, 32'h1001_0020, 32'h0, 4'hF);
      // Misaligned full-word store over a known word 0
      issue(1'b0, 1'b1, 1'b0, 32'h1001_0000, 32'h0F0F_0F0F, 4'hF);
      issue(1'b0, 1'b1, 1'b0, 32'h1001_0002, 32'hCAFE_F00D, 4'hF);
      issue(1'b0, 1'b0, 1'b1, 32'h1001_0000, 32'h0, 4'hF);

      // Reset while instance A sits in WAIT
      @(negedge iCLK);
      cur = 1'b0;
      addr_a = 32'h1001_0008; re_a = 1'b1; be_a = 4'hF;
      @(posedge iCLK);
      #1;
      re_a = 1'b0;
      s0 = strobe_tot;
      r0 = ready_tot;
      @(negedge iCLK);
      check_eq("rst_wait_busy", 32'(busy_a), 32'd1);
      iRST = 1'b1;
      @(posedge iCLK);
      #1;
      iRST = 1'b0;
      @(negedge iCLK);
      check_zero(1'b0, "rst_in_wait");
      repeat (6) @(negedge iCLK);
      check_eq("rst_no_strobe", strobe_tot, s0);
      check_eq("rst_no_ready", ready_tot, r0);
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      issue(1'b0, 1'b0, 1'b1, 32'h1001_0008, 32'h0, 4'hF);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
